// File: rtl/controlador_bus_uart_if.sv
// CPU-style memory bus: address, store data and strobe out, read data back.
// The controller takes the CPU side as slave and drives the RAM side as master.
interface controlador_bus_uart_if;
  logic [31:0] dir;
  logic [31:0] dat_escritura;
  logic        hab_escritura;
  logic [31:0] dat_lectura;

  modport master (output dir, dat_escritura, hab_escritura, input dat_lectura);
  modport slave  (input dir, dat_escritura, hab_escritura, output dat_lectura);
endinterface

// File: rtl/controlador_bus_uart.sv
// Bus splitter: dir[31]=0 goes to RAM, dir[31]=1 to a FIFO-fed UART transmitter.
// Define UART_PARIDAD_EN to add an even-parity bit to each frame (8E1 instead of 8N1).
module controlador_bus_uart #(
  parameter int FIFO_PROF   = 8,
  parameter int DIV_DEFAULT = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  controlador_bus_uart_if.slave  cpu,
  controlador_bus_uart_if.master ram,
  output logic                  tx
);
  localparam int PW = $clog2(FIFO_PROF);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    REPOSO,
    INICIO,
    DATOS,
`ifdef UART_PARIDAD_EN
    PARIDAD,
`endif
    PARADA
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [7:0]    mem [FIFO_PROF];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic        periph, wr_dato, wr_estado, wr_div;
  logic        fifo_full, fifo_empty, pop, push_ok, bit_fin;
  logic [1:0]  reg_sel;
  logic [31:0] periph_rd;
  logic        unused_bits;

  assign ram.dir           = cpu.dir;
  assign ram.dat_escritura = cpu.dat_escritura;
  assign ram.hab_escritura = cpu.hab_escritura & ~cpu.dir[31];

  assign periph    = cpu.dir[31];
  assign reg_sel   = cpu.dir[3:2];
  assign wr_dato   = cpu.hab_escritura & periph & (reg_sel == 2'd0);
  assign wr_estado = cpu.hab_escritura & periph & (reg_sel == 2'd1);
  assign wr_div    = cpu.hab_escritura & periph & (reg_sel == 2'd2);
  assign unused_bits = ^{cpu.dir[30:4], cpu.dir[1:0], cpu.dat_escritura[31:16]};

  assign fifo_full  = (cnt_q == CW'(FIFO_PROF));
  assign fifo_empty = (cnt_q == '0);
  assign bit_fin    = (baud_q == 16'd0);

  always_comb begin
    periph_rd = 32'd0;
    case (reg_sel)
      2'd1:    periph_rd = {16'd0, 8'(cnt_q), 4'd0, ovf_q, (estado_q != REPOSO),
                            fifo_empty, fifo_full};
      2'd2:    periph_rd = {16'd0, div_q};
      default: periph_rd = 32'd0;
    endcase
  end

  assign cpu.dat_lectura = periph ? periph_rd : ram.dat_lectura;

  // Transmitter: every non-idle state lasts one bit time, reloading the baud counter from div_q.
  always_comb begin
    estado_d = estado_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    if (estado_q != REPOSO) begin
      baud_d = bit_fin ? (div_q - 16'd1) : (baud_q - 16'd1);
    end
    case (estado_q)
      REPOSO: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = mem[rd_ptr_q];
          baud_d   = div_q - 16'd1;
          estado_d = INICIO;
        end
      end
      INICIO: begin
        if (bit_fin) begin
          bit_d    = 3'd0;
          estado_d = DATOS;
        end
      end
      DATOS: begin
        if (bit_fin) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARIDAD_EN
            estado_d = PARIDAD;
`else
            estado_d = PARADA;
`endif
          end
        end
      end
`ifdef UART_PARIDAD_EN
      PARIDAD: begin
        if (bit_fin) estado_d = PARADA;
      end
`endif
      PARADA: begin
        if (bit_fin) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = mem[rd_ptr_q];
            estado_d = INICIO;
          end else begin
            estado_d = REPOSO;
          end
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (estado_q)
      INICIO:  tx_d = 1'b0;
      DATOS:   tx_d = shift_q[bit_q];
`ifdef UART_PARIDAD_EN
      PARIDAD: tx_d = ^shift_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  always_comb begin
    push_ok  = wr_dato & (~fifo_full | pop);
    wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (wr_dato & fifo_full & ~pop) ovf_d = 1'b1;
    else if (wr_estado & cpu.dat_escritura[3]) ovf_d = 1'b0;
    div_d = div_q;
    if (wr_div) div_d = (cpu.dat_escritura[15:0] == 16'd0) ? 16'd1 : cpu.dat_escritura[15:0];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= cpu.dat_escritura[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= REPOSO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      div_q    <= 16'(DIV_DEFAULT);
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      estado_q <= estado_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;
endmodule

// File: doc/controlador_bus_uart.md
# controlador_bus_uart

Memory-bus controller placed directly downstream of the `cpu` memory port. It consumes `dir`, `dat_escritura` and `hab_escritura`, and returns `dat_lectura`. Accesses with `dir[31]=0` go to the external RAM. Accesses with `dir[31]=1` go to a memory-mapped UART transmitter, which holds a write FIFO, a programmable baud divisor and a TX state machine.

## Interface
Parameters:
- `FIFO_PROF`, default 8: FIFO depth in bytes. Must be a power of 2, ≥2.
- `DIV_DEFAULT`, default 434: reset value of the divisor, in clock cycles per bit (50 MHz / 115200).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `dir` input 32: address from the CPU.
- `dat_escritura` input 32: store data from the CPU.
- `hab_escritura` input 1: store strobe from the CPU. One cycle high per store.
- `dat_lectura` output 32: read data to the CPU.
- `ram_dir` output 32: RAM address. Equals `dir`.
- `ram_dat_escritura` output 32: equals `dat_escritura`.
- `ram_hab_escritura` output 1: `hab_escritura & ~dir[31]`.
- `ram_dat_lectura` input 32: RAM read data (asynchronous read).
- `tx` output 1: UART serial line. Idles high.

## Operation
Address map. Only `dir[31]` and `dir[3:2]` are decoded in the peripheral space.
- `0x8000_0000` DATO. A write pushes `dat_escritura[7:0]` into the FIFO. Reads return 0.
- `0x8000_0004` ESTADO, read:
  - bit0: FIFO full
  - bit1: FIFO empty
  - bit2: TX busy (state ≠ REPOSO)
  - bit3: sticky overflow
  - bits[15:8]: FIFO occupancy
  - other bits: 0
- ESTADO write: writing 1 to bit3 clears overflow. All other bits are ignored.
- `0x8000_0008` DIVISOR. Read/write, bits[15:0]. Upper bits read as 0. A write of 0 is stored as 1.
- `0x8000_000C`: reads 0, writes ignored.

Read path:
- `dat_lectura` is a combinational mux. `ram_dat_lectura` is selected when `dir[31]=0`, otherwise the peripheral register.
- No added latency: the CPU consumes `dat_lectura` in the same cycle it drives `dir`.

FIFO:
- Circular buffer, `FIFO_PROF` entries, with wrapping read/write pointers and a separate occupancy counter.
- Push into a full FIFO with no simultaneous pop: the byte is dropped and overflow is set.
- Push and pop in the same cycle while full: both happen, occupancy is unchanged, no overflow.

TX FSM, states REPOSO → INICIO → DATOS → [PARIDAD] → PARADA:
- REPOSO: `tx=1`. If the FIFO is not empty, pop into the shift register and go to INICIO.
- INICIO: `tx=0` for one bit time.
- DATOS: 8 bits, LSB first, one bit time each. A 3-bit bit counter selects the bit.
- PARADA: `tx=1` for one bit time.
- At the end of PARADA:
  - FIFO not empty: pop and go directly to INICIO (back-to-back frames, no idle gap).
  - FIFO empty: go to REPOSO.

Baud counter:
- Loaded with DIVISOR−1 at the start of each bit, counts down to 0, and the bit ends at 0.
- A DIVISOR write takes effect at the next bit boundary. The current bit is not truncated.

## Timing
- Reset values:
  - `tx=1`
  - `dat_lectura` follows the combinational mux
  - `ram_*` combinational
  - FIFO empty, pointers 0
  - overflow 0
  - DIVISOR = `DIV_DEFAULT`
  - state REPOSO
- Asserting reset mid-frame aborts the frame immediately: `tx=1`, and FIFO contents are discarded.
- Store latency: the write is registered on the `clk` edge where `hab_escritura=1`. ESTADO reflects the push in the next cycle.
- First frame: the pop happens on the first edge in REPOSO with the FIFO non-empty. `tx` falls on the following edge. The start bit lasts exactly DIVISOR cycles.
- Frame length is 10×DIVISOR cycles, or 11×DIVISOR cycles with parity.
- Frames are back-to-back with zero idle cycles between them.

## Configuration
- `UART_PARIDAD_EN` defined: adds state PARIDAD between DATOS and PARADA. `tx` carries even parity (XOR of the 8 data bits) for one bit time.
- `UART_PARIDAD_EN` undefined: PARIDAD state and its logic are absent, and the frame is 8N1.

## Test plan
- RAM passthrough: write `0x0000_0010`=`0xDEADBEEF` with `hab_escritura=1` → `ram_hab_escritura=1` and `ram_dir=0x10`. Read `0x10` with `ram_dat_lectura=0x1234` → `dat_lectura=0x1234`. A write to `0x8000_0000` → `ram_hab_escritura=0`.
- Single frame: DIVISOR=4, write `0x55` to DATO → `tx` falls 2 cycles later. Line carries 0, 1,0,1,0,1,0,1,0, 1, with each bit exactly 4 cycles. Busy=0 after 40 cycles.
- Back-to-back: push `0x01`, `0x02`, `0x03` on consecutive cycles → three frames with no idle cycle between them. ESTADO reads empty=1 after the third pop.
- Overflow and wrap: `FIFO_PROF`=8, DIVISOR=100, push 10 bytes (0..9) → the first is popped, 8 stored, 1 dropped, and ESTADO bit3=1. Write ESTADO=`0x8` → bit3=0. Bytes 0–8 are transmitted in order.
- Reset mid-frame: assert `reset=0` during DATOS → `tx=1` immediately. After release, ESTADO=`0x0000_0002` and DIVISOR=`DIV_DEFAULT`.
- Parity (with `UART_PARIDAD_EN`): DIVISOR=2, send `0x07` → parity bit=1 and the frame is 22 cycles. Send `0x03` → parity bit=0.
